// File: rtl/vga_sd_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_sd_sync_ctrl
// Description : Measures external video timing in the clkvga domain, locks onto
//               stable modes and drives the scandoubler enable/scanline controls.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sd_sync_ctrl #(
    parameter int HMIN          = 512,
    parameter int HMAX          = 2047,
    parameter int VMIN          = 200,
    parameter int VMAX          = 400,
    parameter int HTOL          = 4,
    parameter int STABLE_FRAMES = 4
) (
    input  logic        clkvga,
    input  logic        rst_n,
    input  logic        hsync_ext_n,
    input  logic        vsync_ext_n,
    input  logic        force_15khz,
    input  logic        scanlines_off,
    output logic [11:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        enable_scandoubling,
    output logic        disable_scaneffect,
    output logic        mode_changed
);

    localparam logic [12:0]        C_HMIN    = 13'(HMIN);
    localparam logic [12:0]        C_HMAX    = 13'(HMAX);
    localparam logic [11:0]        C_HTO     = 12'(HMAX + 1);
    localparam logic [9:0]         C_VMIN    = 10'(VMIN);
    localparam logic [9:0]         C_VMAX    = 10'(VMAX);
    localparam logic signed [12:0] C_HTOL    = 13'(HTOL);
    localparam logic [3:0]         C_STABLE  = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Bit 0 carries hsync, bit 1 carries vsync through the synchroniser.
    logic [1:0]  meta_q, meta_d, sync_q, sync_d, prev_q, prev_d, fall_q, fall_d;
    logic [11:0] hcnt_q, hcnt_d, ref_h_q, ref_h_d, line_len_q, line_len_d;
    logic [12:0] hper_q, hper_d;
    logic [9:0]  vcnt_q, vcnt_d, ref_v_q, ref_v_d, frame_lines_q, frame_lines_d;
    logic [3:0]  stab_q, stab_d;
    logic        fbad_q, fbad_d, en_q, en_d, dis_q, dis_d, mc_q, mc_d;
    state_t      state_q, state_d;

    logic               hfall, vfall, timeout, hper_ok, frame_ok, match, load_ref, enter_lock;
    logic [11:0]        hcnt_inc;
    logic [12:0]        hper_n;
    logic [9:0]         vcnt_n;
    logic               fbad_n;
    logic signed [12:0] hdiff;

    assign hfall    = fall_q[0];
    assign vfall    = fall_q[1];
    assign timeout  = (hcnt_q == C_HTO);
    assign hcnt_inc = (hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1;

    // A coincident hfall is folded into the frame that vfall closes.
    assign hper_n   = hfall ? ({1'b0, hcnt_q} + 13'd1) : hper_q;
    assign vcnt_n   = hfall ? ((vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1) : vcnt_q;
    assign hper_ok  = (hper_n >= C_HMIN) && (hper_n <= C_HMAX);
    assign fbad_n   = fbad_q | (hfall & ~hper_ok);
    assign frame_ok = ~fbad_n && (vcnt_n >= C_VMIN) && (vcnt_n <= C_VMAX) && hper_ok;
    assign hdiff    = $signed({1'b0, hper_n[11:0]}) - $signed({1'b0, ref_h_q});
    assign match    = (hdiff <= C_HTOL) && (hdiff >= -C_HTOL) && (vcnt_n == ref_v_q);

    always_comb begin
        meta_d        = {vsync_ext_n, hsync_ext_n};
        sync_d        = meta_q;
        prev_d        = sync_q;
        fall_d        = prev_q & ~sync_q;
        hcnt_d        = hfall ? 12'd0 : hcnt_inc;
        hper_d        = hper_n;
        vcnt_d        = vcnt_n;
        fbad_d        = fbad_n;
        state_d       = state_q;
        stab_d        = stab_q;
        ref_h_d       = ref_h_q;
        ref_v_d       = ref_v_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        en_d          = en_q;
        dis_d         = dis_q;
        mc_d          = 1'b0;
        load_ref      = 1'b0;
        enter_lock    = 1'b0;

        if (timeout) begin
            state_d = ST_SEARCH;
            stab_d  = 4'd0;
            fbad_d  = 1'b1;
            if (vfall) vcnt_d = 10'd0;
        end else if (vfall) begin
            vcnt_d = 10'd0;
            fbad_d = 1'b0;
            if (!frame_ok) begin
                state_d = ST_SEARCH;
                stab_d  = 4'd0;
            end else begin
                case (state_q)
                    ST_SEARCH: begin
                        load_ref   = 1'b1;
                        enter_lock = (C_STABLE <= 4'd1);
                        state_d    = (C_STABLE <= 4'd1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (match) begin
                            stab_d = stab_q + 4'd1;
                            if ((stab_q + 4'd1) >= C_STABLE) begin
                                state_d    = ST_LOCKED;
                                enter_lock = 1'b1;
                            end
                        end else begin
                            load_ref = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!match) begin
                            load_ref = 1'b1;
                            state_d  = ST_ACQUIRE;
                        end
                    end
                    default: state_d = ST_SEARCH;
                endcase
            end
            if (load_ref) begin
                ref_h_d = hper_n[11:0];
                ref_v_d = vcnt_n;
                stab_d  = 4'd1;
            end
            if (enter_lock) begin
                line_len_d    = ref_h_d;
                frame_lines_d = ref_v_d;
                mc_d          = (ref_h_d != line_len_q) || (ref_v_d != frame_lines_q);
            end
            // User controls are sampled only at frame boundaries.
            if (state_d == ST_LOCKED) begin
                en_d  = ~force_15khz;
                dis_d = scanlines_off;
            end
        end
        if (state_d != ST_LOCKED) en_d = 1'b0;
    end

    always_ff @(posedge clkvga or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= 2'b11;
            sync_q        <= 2'b11;
            prev_q        <= 2'b11;
            fall_q        <= 2'b00;
            hcnt_q        <= 12'd0;
            hper_q        <= 13'd0;
            vcnt_q        <= 10'd0;
            fbad_q        <= 1'b0;
            state_q       <= ST_SEARCH;
            stab_q        <= 4'd0;
            ref_h_q       <= 12'd0;
            ref_v_q       <= 10'd0;
            line_len_q    <= 12'd0;
            frame_lines_q <= 10'd0;
            en_q          <= 1'b0;
            dis_q         <= 1'b0;
            mc_q          <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            fall_q        <= fall_d;
            hcnt_q        <= hcnt_d;
            hper_q        <= hper_d;
            vcnt_q        <= vcnt_d;
            fbad_q        <= fbad_d;
            state_q       <= state_d;
            stab_q        <= stab_d;
            ref_h_q       <= ref_h_d;
            ref_v_q       <= ref_v_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            en_q          <= en_d;
            dis_q         <= dis_d;
            mc_q          <= mc_d;
        end
    end

    assign line_len            = line_len_q;
    assign frame_lines         = frame_lines_q;
    assign locked              = (state_q == ST_LOCKED);
    assign enable_scandoubling = en_q;
    assign disable_scaneffect  = dis_q;
    assign mode_changed        = mc_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sd_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sd_sync_ctrl
// Description : Directed self-checking bench for vga_sd_sync_ctrl with a
//               queue of expected output states checked after each sync edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sd_sync_ctrl;

    localparam int P = 64;
    localparam int N = 12;

    logic        clk = 1'b0;
    logic        rst_n, hs, vs, f15, scl;
    logic [11:0] ll_o;
    logic [9:0]  fl_o;
    logic        lk_o, en_o, dis_o, mc_o;

    int total  = 0;
    int bad    = 0;
    int mc_cnt = 0;

    typedef struct {
        string tag;
        int    dly;
        bit    full;
        logic  lk;
        logic  en;
        logic  dis;
        int    ll;
        int    fl;
        int    mc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (mc_o === 1'b1) mc_cnt <= mc_cnt + 1;

    vga_sd_sync_ctrl #(
        .HMIN(16), .HMAX(127), .VMIN(8), .VMAX(20), .HTOL(2), .STABLE_FRAMES(4)
    ) dut (
        .clkvga              (clk),
        .rst_n               (rst_n),
        .hsync_ext_n         (hs),
        .vsync_ext_n         (vs),
        .force_15khz         (f15),
        .scanlines_off       (scl),
        .line_len            (ll_o),
        .frame_lines         (fl_o),
        .locked              (lk_o),
        .enable_scandoubling (en_o),
        .disable_scaneffect  (dis_o),
        .mode_changed        (mc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int dly, input bit full, input logic lk,
                        input logic en, input logic dis, input int ll, input int fl, input int mc);
        exp_t e;
        e.tag = tag; e.dly = dly; e.full = full; e.lk = lk; e.en = en; e.dis = dis;
        e.ll = ll; e.fl = fl; e.mc = mc;
        sb.push_back(e);
    endtask

    // One line; the pin edge is driven at c==0, so sampling at c==k sees k rising edges since.
    task automatic line(input int per, input bit with_v, input bit chk_en);
        exp_t e;
        for (int c = 0; c < per; c++) begin
            @(negedge clk);
            while (chk_en && sb.size() > 0 && sb[0].dly == c) begin
                e = sb.pop_front();
                chk({e.tag, "_locked"}, 32'(lk_o), 32'(e.lk));
                chk({e.tag, "_en"}, 32'(en_o), 32'(e.en));
                chk({e.tag, "_dis"}, 32'(dis_o), 32'(e.dis));
                if (e.full) begin
                    chk({e.tag, "_line_len"}, 32'(ll_o), e.ll);
                    chk({e.tag, "_frame_lines"}, 32'(fl_o), e.fl);
                    chk({e.tag, "_mc_count"}, mc_cnt, e.mc);
                end
            end
            hs = (c < 4) ? 1'b0 : 1'b1;
            if (with_v) vs = (c < 4) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic frame(input int n, input int per, input int jit, input int bad_line, input int bad_per);
        int p;
        for (int i = 0; i < n; i++) begin
            p = per;
            if (jit != 0) p = (i % 2 == 1) ? per + jit : per - jit;
            if (i == bad_line) p = bad_per;
            line(p, i == 0, i == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; f15 = 1'b0; scl = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(lk_o), 0);
        chk("rst_en", 32'(en_o), 0);
        chk("rst_dis", 32'(dis_o), 0);
        chk("rst_line_len", 32'(ll_o), 0);
        chk("rst_frame_lines", 32'(fl_o), 0);
        chk("rst_mode_changed", 32'(mc_o), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Acquire: partial frame, then four full frames before lock.
        push("L1", 5, 1, 0, 0, 0, 0, 0, 0); frame(N, P, 0, -1, 0);
        push("L2", 5, 1, 0, 0, 0, 0, 0, 0); frame(N, P, 0, -1, 0);
        push("L3", 5, 1, 0, 0, 0, 0, 0, 0); frame(N, P, 0, -1, 0);
        push("L4", 5, 1, 0, 0, 0, 0, 0, 0); frame(N, P, 0, -1, 0);
        push("L5a", 3, 0, 0, 0, 0, 0, 0, 0);
        push("L5b", 4, 0, 1, 1, 0, 0, 0, 0);
        push("L5c", 5, 1, 1, 1, 0, 64, 12, 1);
        frame(N, P, 2, -1, 0);
        push("J2", 5, 1, 1, 1, 0, 64, 12, 1); frame(N, P, 2, -1, 0);

        // Out-of-tolerance period drops to acquire, relocks after four frames.
        push("A1", 5, 1, 1, 1, 0, 64, 12, 1); frame(N, 67, 0, -1, 0);
        push("A2", 5, 1, 0, 0, 0, 64, 12, 1); frame(N, 67, 0, -1, 0);
        push("A3", 5, 1, 0, 0, 0, 64, 12, 1); frame(N, 67, 0, -1, 0);
        push("A4", 5, 1, 0, 0, 0, 64, 12, 1); frame(N, 67, 0, -1, 0);

        // User controls changed mid-frame take effect at the next vsync.
        push("B1", 5, 1, 1, 1, 0, 67, 12, 2); line(67, 1, 1); line(67, 0, 0);
        f15 = 1'b1; scl = 1'b1;
        push("U0", 10, 1, 1, 1, 0, 67, 12, 2); line(67, 0, 1);
        for (int i = 3; i < N; i++) line(67, 0, 0);
        push("U1", 3, 0, 1, 1, 0, 67, 12, 2);
        push("U2", 4, 0, 1, 0, 1, 67, 12, 2);
        push("U3", 5, 1, 1, 0, 1, 67, 12, 2);
        line(67, 1, 1); line(67, 0, 0);
        f15 = 1'b0; scl = 1'b0;
        for (int i = 2; i < N; i++) line(67, 0, 0);

        // Hsync stop: timeout one cycle after hcnt reaches HMAX+1.
        push("B3", 5, 1, 1, 1, 0, 67, 12, 2); line(67, 1, 1);
        push("T0", 132, 0, 1, 1, 0, 67, 12, 2);
        push("T1", 133, 1, 0, 0, 0, 67, 12, 2);
        line(300, 0, 1);
        push("R0", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, 67, 0, -1, 0);
        push("R1", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, 67, 0, -1, 0);
        push("R2", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, 67, 0, -1, 0);
        push("R3", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, 67, 0, -1, 0);
        push("R4", 5, 1, 1, 1, 0, 67, 12, 2); frame(5, P, 0, -1, 0);

        // Too few lines, then a short line inside a frame: never lock.
        push("X2a", 3, 0, 1, 1, 0, 67, 12, 2);
        push("X2b", 4, 0, 0, 0, 0, 67, 12, 2);
        push("X2c", 5, 1, 0, 0, 0, 67, 12, 2); frame(5, P, 0, -1, 0);
        push("X3", 5, 1, 0, 0, 0, 67, 12, 2); frame(5, P, 0, -1, 0);
        push("X4", 5, 1, 0, 0, 0, 67, 12, 2); frame(5, P, 0, -1, 0);
        push("Y1", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, 5, 10);
        push("Y2", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, 5, 10);
        push("Y3", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, 5, 10);
        push("G1", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, -1, 0);
        push("G2", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, -1, 0);
        push("G3", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, -1, 0);
        push("G4", 5, 1, 0, 0, 0, 67, 12, 2); frame(N, P, 0, -1, 0);
        push("G5", 5, 1, 1, 1, 0, 64, 12, 3); line(P, 1, 1); line(P, 0, 0);

        // Asynchronous reset while locked, between clock edges.
        @(negedge clk); #2; rst_n = 1'b0; #1;
        chk("arst_locked", 32'(lk_o), 0);
        chk("arst_en", 32'(en_o), 0);
        chk("arst_dis", 32'(dis_o), 0);
        chk("arst_line_len", 32'(ll_o), 0);
        chk("arst_frame_lines", 32'(fl_o), 0);
        chk("arst_mode_changed", 32'(mc_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        push("H1", 5, 1, 0, 0, 0, 0, 0, 3); frame(N, P, 0, -1, 0);
        push("H2", 5, 1, 0, 0, 0, 0, 0, 3); frame(N, P, 0, -1, 0);
        push("H3", 5, 1, 0, 0, 0, 0, 0, 3); frame(N, P, 0, -1, 0);
        push("H4", 5, 1, 0, 0, 0, 0, 0, 3); frame(N, P, 0, -1, 0);
        push("H5", 5, 1, 1, 1, 0, 64, 12, 4); line(P, 1, 1); line(P, 0, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sd_sync_ctrl.md
# vga_sd_sync_ctrl

Video-timing supervisor and configurator for the VGA scandoubler, running in the `clkvga` domain. It measures the incoming video's line period (in `clkvga` cycles) and lines per frame from the external sync pulses. It decides when the input is stable enough to scandouble, and drives the scandoubler's `enable_scandoubling` and `disable_scaneffect` controls. Those controls change only at frame boundaries, except on loss of sync.

## Interface
- `HMIN`, 512: minimum legal line period, in `clkvga` cycles.
- `HMAX`, 2047: maximum legal line period; also the hsync timeout. Must be < 4095.
- `VMIN`, 200: minimum legal lines per frame.
- `VMAX`, 400: maximum legal lines per frame.
- `HTOL`, 4: allowed ± deviation of the line period from the reference, in cycles.
- `STABLE_FRAMES`, 4: number of consecutive matching valid frames required to lock (1..15).
- `clkvga`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hsync_ext_n`  in  1  source hsync, active low, asynchronous to `clkvga`.
- `vsync_ext_n`  in  1  source vsync, active low, asynchronous to `clkvga`.
- `force_15khz`  in  1  user request for 15 kHz passthrough (level).
- `scanlines_off`  in  1  user request to disable scanline dimming (level).
- `line_len`  out  12  locked reference line period in cycles.
- `frame_lines`  out  10  locked reference lines per frame.
- `locked`  out  1  input timing is stable.
- `enable_scandoubling`  out  1  drives the scandoubler enable.
- `disable_scaneffect`  out  1  drives the scandoubler scanline disable.
- `mode_changed`  out  1  one-cycle pulse when `line_len`/`frame_lines` take new values.

## Operation
- **Input synchronisation:** both sync inputs pass through a 2-FF synchroniser. A falling-edge detector on each synchronised signal produces `hfall` and `vfall`.
- **Line counter `hcnt` (12 bit):** increments every cycle and saturates at 4095.
  - On `hfall`: `hper = hcnt + 1` and `hcnt` returns to 0.
  - If `hper` is outside [HMIN, HMAX], set the frame-bad flag `fbad`.
- **Frame counter `vcnt` (10 bit):** increments on `hfall` and saturates at 1023.
- **Frame end (`vfall`):** evaluate the frame, then clear `vcnt` and `fbad`.
  - A frame is valid when `fbad == 0`, `VMIN <= vcnt <= VMAX`, and the last `hper` is in range.
- **Match rule:** the frame matches when |`hper` − `ref_h`| <= `HTOL` and `vcnt == ref_v`. The difference uses 13-bit signed arithmetic.
- **Coincident edges:** if `hfall` and `vfall` occur in the same cycle, process `hfall` first, so the line counts toward the ending frame.
- **FSM states:**
  - **SEARCH**
    - A valid frame loads `ref_h`/`ref_v`, sets `stab = 1`, and moves to ACQUIRE.
    - An invalid frame stays in SEARCH.
  - **ACQUIRE**
    - A valid, matching frame increments `stab`; when `stab` reaches `STABLE_FRAMES`, move to LOCKED.
    - A valid, non-matching frame reloads the reference and sets `stab = 1`.
    - An invalid frame moves to SEARCH.
  - **LOCKED**
    - A valid, matching frame stays in LOCKED; the reference is not updated.
    - A valid, non-matching frame moves to ACQUIRE (reference reloaded, `stab = 1`).
    - An invalid frame moves to SEARCH.
  - **Timeout (any state):** when `hcnt` reaches `HMAX + 1`, move to SEARCH immediately, clear `stab`, and set `fbad`.
- **On entry to LOCKED:**
  - `line_len <= ref_h` and `frame_lines <= ref_v`.
  - `mode_changed` pulses if either value differs from its previous output.
- **Configuration outputs:**
  - `locked` is 1 exactly while in LOCKED.
  - On `vfall` while LOCKED (including the entry cycle): `enable_scandoubling <= ~force_15khz` and `disable_scaneffect <= scanlines_off`.
  - On leaving LOCKED: `enable_scandoubling <= 0` the same cycle. `disable_scaneffect` holds its value.
  - User input changes mid-frame have no effect until the next `vfall`.

## Timing
- **Reset values:** all outputs 0 and FSM in SEARCH. `hcnt`, `vcnt`, `stab`, `fbad`, `ref_h`, `ref_v` are all 0.
- **Latency:**
  - A pin falling edge produces `hfall`/`vfall` 3 cycles later (2 synchroniser stages + 1 edge register).
  - Registered outputs update 1 cycle after that, i.e. 4 cycles after the pin.
- **Lock time:** `locked` rises 4 cycles after the `vfall` pin edge that ends the `STABLE_FRAMES`-th consecutive matching valid frame. The first valid frame counts as 1.
- **Loss of lock:**
  - Timeout: `locked` and `enable_scandoubling` fall 1 cycle after `hcnt` reaches `HMAX + 1`.
  - Bad frame: they fall 4 cycles after the offending `vsync` pin edge.
- **`mode_changed`:** exactly 1 cycle wide, coincident with the `locked` rise or the reference reload into the outputs.
- **Reset mid-operation:** all state clears asynchronously. After release, the first `vfall` only starts the count (`vcnt` from 0); that partial frame is evaluated as a normal frame.

## Test plan
- **Lock on PAL-like input:** hsync period 1536 cycles, 312 lines/frame.
  - `locked` = 1 after the 4th full frame.
  - `line_len` = 1536, `frame_lines` = 312, one `mode_changed` pulse, `enable_scandoubling` = 1.
- **Jitter within tolerance:** while locked, line periods alternate between 1533 and 1539.
  - `locked` stays 1 and `line_len` stays 1536.
  - Then one frame at 1545 → `locked` = 0 and state ACQUIRE; 4 frames at 1545 relock with `line_len` = 1545.
- **Hsync stop:** hold `hsync_ext_n` high while locked.
  - `locked` and `enable_scandoubling` = 0 exactly 2048 cycles after the last `hfall` + 1.
  - No relock until 4 more good frames.
- **Out-of-range frames:** 150 lines/frame, or a 400-cycle line inside a frame.
  - `locked` never asserts; the FSM stays in SEARCH.
- **User controls:** assert `force_15khz` and `scanlines_off` mid-frame while locked.
  - `enable_scandoubling` = 0 and `disable_scaneffect` = 1 only 4 cycles after the next `vsync` edge.
- **Async reset:** drop `rst_n` while locked.
  - All outputs 0 immediately with no clock edge.
  - After release, lock is reacquired per the lock-time rule.
